// File: rtl/mm_port_arb_if.sv
// Requester-side bundle for one port of mm_port_arb.
// The requester holds its request fields until it sees gnt.
interface mm_port_arb_if #(
  parameter int AW = 32
);
  logic          req;
  logic [1:0]    wr;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mm_port_arb.sv
// Two-requester arbiter/sequencer for the main-memory data port (IDLE -> ISSUE -> RESP).
// Define MM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mm_port_arb #(
  parameter int MEM_BYTES = 256,
  parameter int AW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mm_port_arb_if.slave    r0,
  mm_port_arb_if.slave    r1,
  output logic [1:0]      mm_wr,
  output logic [AW-1:0]   mm_d_in_addr,
  output logic [AW-1:0]   mm_d_out_addr,
  output logic [31:0]     mm_d_in,
  input  logic [31:0]     mm_d_out
);

  localparam logic [1:0]  WR_NONE = 2'd0;
  localparam logic [1:0]  WR_B    = 2'd1;
  localparam logic [1:0]  WR_HW   = 2'd2;
  localparam logic [AW:0] LIMIT   = (AW+1)'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_reg;
  logic          owner_reg;
  logic          read_reg;
  logic [1:0]    gnt_reg;
  logic [1:0]    err_reg;
  logic [1:0]    rvalid_reg;
  logic [1:0]    mm_wr_reg;
  logic [AW-1:0] mm_d_in_addr_reg;
  logic [AW-1:0] mm_d_out_addr_reg;
  logic [31:0]   mm_d_in_reg;

  logic [1:0]    req;
  logic [1:0]    wr_in    [2];
  logic [AW-1:0] addr_in  [2];
  logic [31:0]   wdata_in [2];
  logic [1:0]    legal;
  logic          win;

  assign req         = {r1.req, r0.req};
  assign wr_in[0]    = r0.wr;
  assign wr_in[1]    = r1.wr;
  assign addr_in[0]  = r0.addr;
  assign addr_in[1]  = r1.addr;
  assign wdata_in[0] = r0.wdata;
  assign wdata_in[1] = r1.wdata;

  // Legality is judged on the live request so ISSUE can act on a registered decision.
  // The last-byte address is one bit wider than AW so it can never wrap.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_legal
      logic [AW:0] last;
      logic        aligned;
      always_comb begin
        last    = {1'b0, addr_in[gi]} + (AW+1)'(3);
        aligned = (addr_in[gi][1:0] == 2'b00);
        case (wr_in[gi])
          WR_B: begin
            last    = {1'b0, addr_in[gi]};
            aligned = 1'b1;
          end
          WR_HW: begin
            last    = {1'b0, addr_in[gi]} + (AW+1)'(1);
            aligned = ~addr_in[gi][0];
          end
          default: ;
        endcase
      end
      assign legal[gi] = aligned && (last < LIMIT);
    end
  endgenerate

`ifdef MM_ARB_RR_EN
  logic ptr_reg;

  assign win = (req == 2'b11) ? ptr_reg : req[1];

  // Pointer moves to the requester that did not just win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (state_reg == IDLE && |req) begin
      ptr_reg <= ~win;
    end
  end
`else
  assign win = ~req[0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      owner_reg         <= 1'b0;
      read_reg          <= 1'b0;
      gnt_reg           <= 2'b00;
      err_reg           <= 2'b00;
      rvalid_reg        <= 2'b00;
      mm_wr_reg         <= WR_NONE;
      mm_d_in_addr_reg  <= '0;
      mm_d_out_addr_reg <= '0;
      mm_d_in_reg       <= '0;
    end else begin
      gnt_reg          <= 2'b00;
      err_reg          <= 2'b00;
      rvalid_reg       <= 2'b00;
      mm_wr_reg        <= WR_NONE;
      mm_d_in_addr_reg <= '0;
      mm_d_in_reg      <= '0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            owner_reg <= win;
            gnt_reg   <= win ? 2'b10 : 2'b01;
            read_reg  <= 1'b0;
            state_reg <= ISSUE;
            if (!legal[win]) begin
              err_reg <= win ? 2'b10 : 2'b01;
            end else if (wr_in[win] == WR_NONE) begin
              read_reg          <= 1'b1;
              mm_d_out_addr_reg <= addr_in[win];
            end else begin
              mm_wr_reg        <= wr_in[win];
              mm_d_in_addr_reg <= addr_in[win];
              mm_d_in_reg      <= wdata_in[win];
            end
          end
        end
        ISSUE: begin
          if (read_reg) begin
            rvalid_reg <= owner_reg ? 2'b10 : 2'b01;
            state_reg  <= RESP;
          end else begin
            state_reg <= IDLE;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mm_wr         = mm_wr_reg;
  assign mm_d_in_addr  = mm_d_in_addr_reg;
  assign mm_d_out_addr = mm_d_out_addr_reg;
  assign mm_d_in       = mm_d_in_reg;

  assign r0.gnt    = gnt_reg[0];
  assign r0.err    = err_reg[0];
  assign r0.rvalid = rvalid_reg[0];
  assign r0.rdata  = mm_d_out;
  assign r1.gnt    = gnt_reg[1];
  assign r1.err    = err_reg[1];
  assign r1.rvalid = rvalid_reg[1];
  assign r1.rdata  = mm_d_out;

endmodule

// File: tb/tb_mm_port_arb.sv
// Directed bench for mm_port_arb with a 256-byte memory stand-in (1-cycle registered read).
// Expected owner order in the tie test follows MM_ARB_RR_EN.
module tb_mm_port_arb;
  localparam int AW = 32;
  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_B    = 2'd1;
  localparam logic [1:0] WR_HW   = 2'd2;
  localparam logic [1:0] WR_W    = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mm_wr;
  logic [AW-1:0] mm_d_in_addr;
  logic [AW-1:0] mm_d_out_addr;
  logic [31:0]   mm_d_in;
  logic [31:0]   mm_d_out = '0;
  logic [7:0]    mem [256];

  int checks = 0;
  int errors = 0;

  mm_port_arb_if #(.AW(AW)) r0_if ();
  mm_port_arb_if #(.AW(AW)) r1_if ();

  mm_port_arb #(.MEM_BYTES(256), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r0            (r0_if),
    .r1            (r1_if),
    .mm_wr         (mm_wr),
    .mm_d_in_addr  (mm_d_in_addr),
    .mm_d_out_addr (mm_d_out_addr),
    .mm_d_in       (mm_d_in),
    .mm_d_out      (mm_d_out)
  );

  always #5 clk = ~clk;

  // Memory stand-in: byte-addressed, little-endian, registered read.
  always @(posedge clk) begin
    automatic int wa = int'(mm_d_in_addr[7:0]);
    automatic int ra = int'(mm_d_out_addr[7:0]);
    if (mm_wr == WR_B) begin
      mem[wa] <= mm_d_in[7:0];
    end else if (mm_wr == WR_HW) begin
      mem[wa]             <= mm_d_in[7:0];
      mem[(wa + 1) & 255] <= mm_d_in[15:8];
    end else if (mm_wr == WR_W) begin
      mem[wa]             <= mm_d_in[7:0];
      mem[(wa + 1) & 255] <= mm_d_in[15:8];
      mem[(wa + 2) & 255] <= mm_d_in[23:16];
      mem[(wa + 3) & 255] <= mm_d_in[31:24];
    end
    mm_d_out <= {mem[(ra + 3) & 255], mem[(ra + 2) & 255], mem[(ra + 1) & 255], mem[ra]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic drive(input int n, input logic req, input logic [1:0] wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (n == 0) begin
      r0_if.req = req; r0_if.wr = wr; r0_if.addr = addr; r0_if.wdata = wdata;
    end else begin
      r1_if.req = req; r1_if.wr = wr; r1_if.addr = addr; r1_if.wdata = wdata;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pulses"}, {r0_if.gnt, r0_if.err, r0_if.rvalid, r1_if.gnt, r1_if.err, r1_if.rvalid}, 0);
    chk({tag, "_mm_wr"}, mm_wr, WR_NONE);
  endtask

  logic [3:0] exp_owner;
  int gcount;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
`ifdef MM_ARB_RR_EN
    exp_owner = 4'b1010;
`else
    exp_owner = 4'b0000;
`endif
    rst_n = 1'b0;
    drive(0, 1'b0, WR_NONE, 0, 0);
    drive(1, 1'b0, WR_NONE, 0, 0);
    for (int c = 0; c < 3; c++) begin
      nx();
      chk_quiet("reset");
      chk("reset_addrs", {mm_d_in_addr, mm_d_out_addr, mm_d_in}, 0);
    end
    $display("txn reset: initial reset checked");

    // Test 1: reset held 3 cycles while a read response is pending
    rst_n = 1'b1;
    drive(1, 1'b1, WR_NONE, 32'h20, 0);
    nx();
    chk("t1_gnt1", r1_if.gnt, 1'b1);
    chk("t1_raddr", mm_d_out_addr, 32'h20);
    rst_n = 1'b0;
    drive(1, 1'b0, WR_NONE, 0, 0);
    for (int c = 0; c < 3; c++) begin
      nx();
      chk_quiet("t1_rst");
      chk("t1_raddr_clr", mm_d_out_addr, 0);
    end
    rst_n = 1'b1;
    nx();
    chk_quiet("t1_after");
    $display("txn t1: reset mid-read, no rvalid");

    // Test 2: R0 word write
    drive(0, 1'b1, WR_W, 32'h10, 32'hDEADBEEF);
    nx();
    chk("t2_gnt0", r0_if.gnt, 1'b1);
    chk("t2_err0", r0_if.err, 1'b0);
    chk("t2_mm_wr", mm_wr, WR_W);
    chk("t2_waddr", mm_d_in_addr, 32'h10);
    chk("t2_wdata", mm_d_in, 32'hDEADBEEF);
    chk("t2_r1", {r1_if.gnt, r1_if.err, r1_if.rvalid}, 0);
    drive(0, 1'b0, WR_NONE, 0, 0);
    nx();
    chk_quiet("t2_after");
    chk("t2_wdata_clr", mm_d_in, 0);
    $display("txn t2: R0 W write 0x10 = deadbeef");

    // Test 3: R1 read back
    drive(1, 1'b1, WR_NONE, 32'h10, 0);
    nx();
    chk("t3_gnt1", r1_if.gnt, 1'b1);
    chk("t3_r0", {r0_if.gnt, r0_if.err, r0_if.rvalid}, 0);
    chk("t3_raddr", mm_d_out_addr, 32'h10);
    chk("t3_mm_wr", mm_wr, WR_NONE);
    drive(1, 1'b0, WR_NONE, 0, 0);
    nx();
    chk("t3_rvalid1", r1_if.rvalid, 1'b1);
    chk("t3_rdata1", r1_if.rdata, 32'hDEADBEEF);
    chk("t3_r0b", {r0_if.gnt, r0_if.err, r0_if.rvalid}, 0);
    chk("t3_gnt1_off", r1_if.gnt, 1'b0);
    nx();
    chk_quiet("t3_after");
    $display("txn t3: R1 read 0x10 = %h", 32'hDEADBEEF);

    // Test 4: legality
    drive(0, 1'b1, WR_HW, 32'h11, 32'h1234);
    nx();
    chk("t4a_gnt0", r0_if.gnt, 1'b1);
    chk("t4a_err0", r0_if.err, 1'b1);
    chk("t4a_mm_wr", mm_wr, WR_NONE);
    drive(0, 1'b0, WR_NONE, 0, 0);
    nx();
    chk_quiet("t4a_after");
    $display("txn t4a: R0 HW write 0x11 rejected");

    drive(1, 1'b1, WR_NONE, 32'hFC, 0);
    nx();
    chk("t4b_gnt1", r1_if.gnt, 1'b1);
    chk("t4b_err1", r1_if.err, 1'b0);
    drive(1, 1'b0, WR_NONE, 0, 0);
    nx();
    chk("t4b_rvalid1", r1_if.rvalid, 1'b1);
    chk("t4b_rdata1", r1_if.rdata, 32'hFFFEFDFC);
    nx();
    $display("txn t4b: R1 read 0xFC accepted");

    drive(1, 1'b1, WR_NONE, 32'h100, 0);
    nx();
    chk("t4c_gnt1", r1_if.gnt, 1'b1);
    chk("t4c_err1", r1_if.err, 1'b1);
    drive(1, 1'b0, WR_NONE, 0, 0);
    nx();
    chk_quiet("t4c_after");
    $display("txn t4c: R1 read 0x100 rejected");

    drive(0, 1'b1, WR_B, 32'hFF, 32'hA5);
    nx();
    chk("t4d_err0", {r0_if.gnt, r0_if.err}, 2'b10);
    chk("t4d_mm_wr", mm_wr, WR_B);
    chk("t4d_waddr", mm_d_in_addr, 32'hFF);
    drive(0, 1'b0, WR_NONE, 0, 0);
    nx();
    $display("txn t4d: R0 B write 0xFF accepted");

    // Test 5: both requesters hold REQ for four reads
    rst_n = 1'b0;
    nx();
    rst_n = 1'b1;
    gcount = 0;
    drive(0, 1'b1, WR_NONE, 32'h20, 0);
    drive(1, 1'b1, WR_NONE, 32'h40, 0);
    for (int c = 0; c < 12; c++) begin
      nx();
      if (r0_if.gnt || r1_if.gnt) begin
        chk("t5_onehot", r0_if.gnt & r1_if.gnt, 1'b0);
        if (gcount < 4) chk("t5_owner", r1_if.gnt, exp_owner[gcount]);
        $display("txn t5: grant %0d to R%0d", gcount, r1_if.gnt);
        gcount++;
      end
      if (r0_if.rvalid) chk("t5_rdata0", r0_if.rdata, 32'h23222120);
      if (r1_if.rvalid) chk("t5_rdata1", r1_if.rdata, 32'h43424140);
    end
    drive(0, 1'b0, WR_NONE, 0, 0);
    drive(1, 1'b0, WR_NONE, 0, 0);
    chk("t5_grants", gcount, 4);
    nx();
    nx();

    // Test 6: back-to-back write then read of the same address
    drive(0, 1'b1, WR_W, 32'h30, 32'h12345678);
    nx();
    chk("t6_gnt_w", r0_if.gnt, 1'b1);
    chk("t6_mm_wr", mm_wr, WR_W);
    drive(0, 1'b1, WR_NONE, 32'h30, 0);
    nx();
    chk("t6_idle", r0_if.gnt, 1'b0);
    nx();
    chk("t6_gnt_r", r0_if.gnt, 1'b1);
    drive(0, 1'b0, WR_NONE, 0, 0);
    nx();
    chk("t6_rvalid", r0_if.rvalid, 1'b1);
    chk("t6_rdata", r0_if.rdata, 32'h12345678);
    nx();
    chk_quiet("t6_after");
    $display("txn t6: R0 write/read 0x30 = %h", 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
